// File: rtl/hvac_ctrl_param.sv
// hvac_ctrl_param: parametrised thermostat with hysteresis, min dwell, sensor watchdog and enable
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   enable      : 1 = regulate, 0 = force IDLE
//   temp_valid  : temperature sample valid this cycle
//   temperature : unsigned TEMP_W-bit sample
//   heating     : heater on (state == HEAT)
//   cooling     : cooler on (state == COOL)
//   fault       : sensor timeout (state == FAULT)
//   state       : 0 IDLE, 1 HEAT, 2 COOL, 3 FAULT
module hvac_ctrl_param #(
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temperature,
    output logic              heating,
    output logic              cooling,
    output logic              fault,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2, FAULT = 2'd3} state_t;

    localparam int DW = MIN_DWELL > 1 ? $clog2(MIN_DWELL) : 1;
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DMAX = DW'(MIN_DWELL - 1);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);
    localparam logic [TEMP_W-1:0] H_ON  = HEAT_ON[TEMP_W-1:0];
    localparam logic [TEMP_W-1:0] H_OFF = HEAT_OFF[TEMP_W-1:0];
    localparam logic [TEMP_W-1:0] C_ON  = COOL_ON[TEMP_W-1:0];
    localparam logic [TEMP_W-1:0] C_OFF = COOL_OFF[TEMP_W-1:0];
    localparam longint TLIM = longint'(1) << TEMP_W;

    if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON))
        begin : g_bad_order
            $fatal(1, "hvac_ctrl_param: thresholds must satisfy HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON");
        end
    if (HEAT_ON < 0 || longint'(COOL_ON) >= TLIM)
        begin : g_bad_range
            $fatal(1, "hvac_ctrl_param: thresholds must fit in TEMP_W bits");
        end
    if (MIN_DWELL < 1 || TIMEOUT < 2)
        begin : g_bad_timing
            $fatal(1, "hvac_ctrl_param: need MIN_DWELL >= 1 and TIMEOUT >= 2");
        end

    state_t          st, nxt;
    logic [DW-1:0]   dwell_cnt;
    logic [WW-1:0]   wdog_cnt;
    logic            dwell_ok, wdog_expire, wdog_clr;

    assign dwell_ok    = dwell_cnt == DMAX;
    assign wdog_expire = wdog_cnt == WMAX && !temp_valid && enable;
    // clearing on expiry too keeps the counter from wrapping on the FAULT entry edge
    assign wdog_clr    = temp_valid || !enable || st == FAULT || wdog_expire;
    assign state       = st;

    always_comb begin
        nxt = wdog_expire      ? FAULT :
              st == FAULT      ? (temp_valid ? IDLE : FAULT) :
              !enable          ? IDLE :
              !temp_valid      ? st :
              st == IDLE       ? (temperature <= H_ON ? HEAT : temperature >= C_ON ? COOL : IDLE) :
              st == HEAT       ? (temperature >= H_OFF && dwell_ok ? IDLE : HEAT) :
              (temperature <= C_OFF && dwell_ok) ? IDLE : COOL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            heating   <= 1'b0;
            cooling   <= 1'b0;
            fault     <= 1'b0;
            dwell_cnt <= '0;
            wdog_cnt  <= '0;
        end else begin
            st        <= nxt;
            heating   <= nxt == HEAT;
            cooling   <= nxt == COOL;
            fault     <= nxt == FAULT;
            dwell_cnt <= nxt != st ? '0 : dwell_ok ? dwell_cnt : dwell_cnt + 1'b1;
            wdog_cnt  <= wdog_clr ? '0 : wdog_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hvac_ctrl_param.sv
// tb_hvac_ctrl_param: directed self-checking bench for hvac_ctrl_param
module tb_hvac_ctrl_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       temp_valid;
    logic [4:0] temperature;
    logic       heating, cooling, fault;
    logic [1:0] state;
    logic       heating1, cooling1, fault1;
    logic [1:0] state1;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    hvac_ctrl_param u_dut (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temperature), .heating(heating), .cooling(cooling),
        .fault(fault), .state(state)
    );

    hvac_ctrl_param #(.MIN_DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temperature), .heating(heating1), .cooling(cooling1),
        .fault(fault1), .state(state1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic v, input int t);
        enable      = en;
        temp_valid  = v;
        temperature = 5'(t);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int seq[$];
        logic mh, mc;
        rst = 1'b1; enable = 1'b0; temp_valid = 1'b0; temperature = '0;
        #12;
        check("rst_state", state, 0);
        check("rst_heat", heating, 0);
        check("rst_cool", cooling, 0);
        check("rst_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;

        // dwell: 17 once, then 21 held
        step(1, 1, 17);
        check("dw_enter_heat", heating, 1);
        check("dw_enter_state", state, 1);
        check("dw1_enter_heat", heating1, 1);
        step(1, 1, 21);
        check("dw_hold1", heating, 1);
        check("dw1_exit_heat", heating1, 0);
        check("dw1_exit_state", state1, 0);
        step(1, 1, 21);
        check("dw_hold2", heating, 1);
        step(1, 1, 21);
        check("dw_hold3", heating, 1);
        step(1, 1, 21);
        check("dw_exit_heat", heating, 0);
        check("dw_exit_state", state, 0);

        // hysteresis sweep 20->25->15->25, 5 cycles per value
        for (int t = 20; t <= 25; t++) seq.push_back(t);
        for (int t = 24; t >= 15; t--) seq.push_back(t);
        for (int t = 16; t <= 25; t++) seq.push_back(t);
        mh = 1'b0; mc = 1'b0;
        foreach (seq[i]) for (int k = 0; k < 5; k++) begin
            step(1, 1, seq[i]);
            if (mh) mh = seq[i] < 20;
            else if (mc) mc = seq[i] > 20;
            else begin
                mh = seq[i] <= 18;
                mc = seq[i] >= 22;
            end
            check($sformatf("sw_heat_t%0d", seq[i]), heating, mh);
            check($sformatf("sw_cool_t%0d", seq[i]), cooling, mc);
            check("sw_exclusive", heating & cooling, 0);
        end

        // watchdog: last valid 20 (leaves COOL), then silence
        step(1, 1, 20);
        check("wd_idle", state, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 20);
        check("wd_no_fault_15", fault, 0);
        step(1, 0, 20);
        check("wd_fault", fault, 1);
        check("wd_state", state, 3);
        check("wd_heat", heating, 0);
        check("wd_cool", cooling, 0);
        step(1, 1, 17);
        check("wd_recover_idle", state, 0);
        check("wd_recover_fault", fault, 0);
        step(1, 1, 17);
        check("wd_then_heat", state, 1);

        // enable override in HEAT with dwell_cnt=1
        step(1, 1, 19);
        check("en_still_heat", state, 1);
        step(0, 0, 19);
        check("en_idle", state, 0);
        check("en_heat_off", heating, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 19);
        check("en_no_fault", fault, 0);
        check("en_state", state, 0);

        // valid exactly on the 16th silent cycle
        step(1, 1, 20);
        for (int i = 0; i < 15; i++) step(1, 0, 20);
        step(1, 1, 20);
        check("ex_no_fault", fault, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 20);
        check("ex_restart_no_fault", fault, 0);
        step(1, 0, 20);
        check("ex_restart_fault", fault, 1);

        // into COOL, then async reset between edges
        step(1, 1, 23);
        check("ar_idle", state, 0);
        step(1, 1, 23);
        check("ar_cool", cooling, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_cool_drop", cooling, 0);
        check("ar_state_drop", state, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ar_cool_again", cooling, 1);
        check("ar_state_again", state, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hvac_ctrl_param.md
Name: hvac_ctrl_param

Overview:
- Parametrised single-zone thermostat controller with hysteresis, for the end-to-end temperature-control design.
- Samples a TEMP_W-bit temperature on a valid strobe and drives mutually exclusive heating/cooling enables.
- Adds over the fixed-threshold controller:
  - a minimum-dwell (anti-short-cycle) timer;
  - a sensor watchdog with a FAULT state;
  - a global enable.

Parameters:
TEMP_W, 5, temperature width in bits (unsigned degrees)
HEAT_ON, 18, start heating when temp <= HEAT_ON
HEAT_OFF, 20, stop heating when temp >= HEAT_OFF
COOL_ON, 22, start cooling when temp >= COOL_ON
COOL_OFF, 20, stop cooling when temp <= COOL_OFF
MIN_DWELL, 4, minimum cycles spent in HEAT or COOL before a threshold exit (>=1)
TIMEOUT, 16, consecutive enabled cycles without temp_valid before FAULT (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  1 = regulate; 0 = force IDLE
temp_valid  input  1  temperature sample valid this cycle
temperature  input  TEMP_W  unsigned temperature sample
heating  output  1  heater on
cooling  output  1  cooler on
fault  output  1  sensor timeout fault
state  output  2  current state: 0 IDLE, 1 HEAT, 2 COOL, 3 FAULT

Behaviour:
- Reset (async, rst=1): state=IDLE, heating=0, cooling=0, fault=0, dwell_cnt=0, wdog_cnt=0. Reset mid-HEAT/COOL drops outputs immediately, without waiting for a clock edge.
- Outputs are registered decodes of state:
  - heating = (state==HEAT)
  - cooling = (state==COOL)
  - fault = (state==FAULT)
  - heating and cooling are never both 1.
- Latency: a qualifying sample with temp_valid=1 at edge N shows on the outputs after edge N, i.e. one cycle.
- Thresholds are evaluated only in cycles with temp_valid=1. Without a valid sample, state holds (subject to enable and watchdog).
- Dwell counter:
  - Loads 0 on any state change.
  - Otherwise increments, saturating at MIN_DWELL-1.
  - dwell_ok = (dwell_cnt == MIN_DWELL-1).
  - MIN_DWELL=1 means no restriction.
- Watchdog counter:
  - Cleared when temp_valid=1 or enable=0 or state==FAULT.
  - Otherwise increments.
  - wdog_expire = (wdog_cnt == TIMEOUT-1) && !temp_valid && enable.
- Next-state priority, highest first:
  1. wdog_expire -> FAULT.
  2. state==FAULT: temp_valid=1 -> IDLE; else stay. enable is ignored in FAULT.
  3. enable=0 -> IDLE. The dwell restriction is overridden.
  4. IDLE: temp <= HEAT_ON -> HEAT; temp >= COOL_ON -> COOL; else stay.
  5. HEAT: temp >= HEAT_OFF && dwell_ok -> IDLE; else stay.
  6. COOL: temp <= COOL_OFF && dwell_ok -> IDLE; else stay.
- No direct HEAT<->COOL transition. The path always goes through at least one IDLE cycle, and a fresh valid sample is needed to leave IDLE.
- A sample meeting an exit threshold before dwell_ok is ignored. It is not remembered; a later valid sample must re-qualify.
- Comparisons are unsigned TEMP_W-bit. Temperatures 0 and 2^TEMP_W-1 need no special handling.
- Elaboration-time check (fatal if violated):
  - HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON
  - all thresholds < 2^TEMP_W
  - MIN_DWELL >= 1, TIMEOUT >= 2
- Counter widths: $clog2 of MIN_DWELL and TIMEOUT respectively, minimum 1 bit.

Test Plan (default parameters):
1. Hysteresis sweep: enable=1, temp_valid=1 every cycle, temperature ramps 20->25->15->25, holding each value 5 cycles.
   - heating rises the cycle after temp=18 is sampled, falls the cycle after 20.
   - cooling rises after 22, falls after 20.
   - Never both high.
2. Dwell: in IDLE, sample 17 for one cycle, then 21 continuously.
   - heating stays 1 for exactly 4 cycles, then state=IDLE.
   - Repeat with MIN_DWELL=1: heating lasts 1 cycle.
3. Watchdog: enable=1, valid sample 20, then temp_valid=0.
   - fault=1 and state=3 exactly 16 cycles later; heating and cooling are 0.
   - Next valid sample 17: state IDLE, then HEAT on the following sample.
4. Valid on expiry cycle: temp_valid pulses exactly at cycle 16 of silence -> no FAULT, wdog_cnt restarts.
5. Enable override: in HEAT with dwell_cnt=1, drop enable -> IDLE next edge.
   - With enable=0 for 40 cycles and no valid: no FAULT.
6. Async reset: assert rst mid-COOL between clock edges -> cooling=0 and state=0 immediately.
   - Release with temp=23 valid: COOL again one cycle after the first edge.
